// File: rtl/ser_tx.sv
// Serial transmitter: valid/ready word in, framed line out (start 0, data LSB-first, stop 1).
// Every output is a register; each line level is held for CLKS_PER_BIT clocks.
module ser_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    tmr, tmr_nx;
    logic [BW-1:0]    bit_idx, bit_nx;
    logic [WIDTH-1:0] shift, shift_nx, shifted;
    logic             tx_nx, ready_nx, busy_nx, done_nx, last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tmr     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_nx;
            tmr     <= tmr_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
            tx_o    <= tx_nx;
            ready_o <= ready_nx;
            busy_o  <= busy_nx;
            done_o  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        bit_nx   = bit_idx;
        shift_nx = shift;
        tx_nx    = tx_o;
        ready_nx = ready_o;
        busy_nx  = busy_o;
        done_nx  = 1'b0;
        last     = (tmr == T_LAST);
        shifted  = shift >> 1;
        if (state != IDLE)
            tmr_nx = last ? '0 : tmr + TW'(1);
        case (state)
            IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                // ready only rises one edge after reset release; accept needs it already high
                if (!ready_o) begin
                    ready_nx = 1'b1;
                end else if (valid_i) begin
                    shift_nx = data_i;
                    state_nx = START;
                    tx_nx    = 1'b0;
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                    tmr_nx   = '0;
                    bit_nx   = '0;
                end
            end
            START: begin
                if (last) begin
                    state_nx = DATA;
                    tx_nx    = shift[0];
                end
            end
            DATA: begin
                if (last) begin
                    if (bit_idx == B_LAST) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        shift_nx = shifted;
                        tx_nx    = shifted[0];
                        bit_nx   = bit_idx + BW'(1);
                    end
                end
            end
            STOP: begin
                if (last) begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx: a CLKS_PER_BIT=4 and a CLKS_PER_BIT=1 instance, with frame
// levels queued at accept and popped cycle by cycle as the line is observed.
module tb_ser_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;
    int         errors = 0;
    int         checks = 0;
    logic       exp_q[$];

    always #5 clk = ~clk;

    ser_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_a (
        .clk(clk), .reset(reset), .valid_i(valid_a), .data_i(data_a),
        .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a));

    ser_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_b (
        .clk(clk), .reset(reset), .valid_i(valid_b), .data_i(data_b),
        .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin valid_b = v; data_b = d; end
        else     begin valid_a = v; data_a = d; end
    endtask

    function automatic logic o_rdy(input bit sel);  return sel ? ready_b : ready_a; endfunction
    function automatic logic o_tx(input bit sel);   return sel ? tx_b    : tx_a;    endfunction
    function automatic logic o_busy(input bit sel); return sel ? busy_b  : busy_a;  endfunction
    function automatic logic o_done(input bit sel); return sel ? done_b  : done_a;  endfunction

    // mode 0: drop valid after accept; 1: keep valid high; 2: scramble data/valid mid-frame.
    // imm=1 requires the accept on the very next edge (back-to-back gap check).
    task automatic frame(input bit sel, input int cpb, input logic [7:0] d,
                         input int mode, input bit imm);
        int   waits = 0;
        logic exp;
        drive(sel, 1'b1, d);
        while (!o_rdy(sel) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("accept_timeout", 32'(waits < 50), 32'd1);
        if (waits >= 50) begin
            drive(sel, 1'b0, d);
            return;
        end
        if (imm) chk("b2b_idle_gap", 32'(waits), 32'd0);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(1'b1);
        for (int lvl = 0; lvl < 10; lvl++) begin
            exp = exp_q.pop_front();
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                if (mode == 0 && lvl == 0 && c == 0) drive(sel, 1'b0, d);
                if (mode == 2) drive(sel, logic'((lvl + c) % 2), 8'hFF);
                chk($sformatf("tx_l%0d_c%0d", lvl, c), 32'(o_tx(sel)), 32'(exp));
                chk("busy_in_frame", 32'(o_busy(sel)), 32'd1);
                chk("ready_in_frame", 32'(o_rdy(sel)), 32'd0);
                chk("done_in_frame", 32'(o_done(sel)), 32'd0);
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(o_done(sel)), 32'd1);
        chk("ready_at_done", 32'(o_rdy(sel)), 32'd1);
        chk("busy_at_done", 32'(o_busy(sel)), 32'd0);
        chk("tx_idle_at_done", 32'(o_tx(sel)), 32'd1);
        if (mode == 2) drive(sel, 1'b0, 8'hFF);
    endtask

    initial begin
        int waits;
        // 1: reset held for 3 cycles, then release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx_a), 32'd1);
            chk("rst_ready", 32'(ready_a), 32'd0);
            chk("rst_busy", 32'(busy_a), 32'd0);
            chk("rst_done", 32'(done_a), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(ready_a), 32'd1);
        chk("ready_b_after_release", 32'(ready_b), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_tx", 32'(tx_a), 32'd1);
            chk("idle_busy", 32'(busy_a), 32'd0);
        end

        // 2: single 0xA5 frame, done exactly once
        frame(1'b0, 4, 8'hA5, 0, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_a), 32'd0);
        chk("ready_stays", 32'(ready_a), 32'd1);

        // 3: back-to-back with valid held high
        frame(1'b0, 4, 8'h00, 1, 1'b0);
        frame(1'b0, 4, 8'hFF, 0, 1'b1);
        @(negedge clk);

        // 4: inputs changed mid-frame must not affect the frame
        frame(1'b0, 4, 8'h3C, 2, 1'b0);
        @(negedge clk);
        chk("no_reaccept_busy", 32'(busy_a), 32'd0);
        chk("no_reaccept_tx", 32'(tx_a), 32'd1);

        // 5: reset during data bit 3 (0x52 has bit 3 = 0 so the jump to 1 is visible)
        drive(1'b0, 1'b1, 8'h52);
        waits = 0;
        while (!ready_a && waits < 50) begin @(negedge clk); waits++; end
        chk("rst_frame_accept_timeout", 32'(waits < 50), 32'd1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 1'b0, 8'h52);
        end
        chk("bit3_before_reset", 32'(tx_a), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx_a), 32'd1);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        chk("async_rst_ready", 32'(ready_a), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("no_done_in_reset", 32'(done_a), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("no_done_after_abort", 32'(done_a), 32'd0);
        chk("ready_after_rerelease", 32'(ready_a), 32'd1);
        frame(1'b0, 4, 8'h81, 0, 1'b0);
        @(negedge clk);

        // 6: single-clock bits
        frame(1'b1, 1, 8'h01, 0, 1'b0);
        @(negedge clk);
        chk("b_done_one_cycle", 32'(done_b), 32'd0);
        chk("b_idle_tx", 32'(tx_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ser_tx.md
Name: ser_tx

Overview:
Single-bit serial transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a one-wire line as a framed sequence. Frame is start bit (0), WIDTH data bits LSB-first, stop bit (1). Each bit is held for CLKS_PER_BIT clocks. Output line is registered and idles high. This is the driving end for a downstream flip-flop sampler on the same line.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CLKS_PER_BIT, 4, clocks each serial bit is held (>=1; value 1 must work)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
valid_i  input  1  word on data_i is offered
data_i  input  WIDTH  word to transmit, sampled only at accept
ready_o  output  1  transmitter can accept a word (registered)
tx_o  output  1  serial line (registered), idles 1
busy_o  output  1  frame in progress (registered)
done_o  output  1  one-cycle pulse at end of frame (registered)

Behaviour:
- Reset (reset=0): asynchronous, no clock needed. tx_o=1, ready_o=0, busy_o=0, done_o=0, state=IDLE, counters=0. Asserting reset mid-frame abandons the frame: tx_o returns to 1 immediately and no done_o is produced.
- ready_o goes to 1 on the first rising edge after reset is released.
- FSM states:
  - IDLE: ready_o=1, tx_o=1.
  - START: tx_o=0.
  - DATA: tx_o=shift[0].
  - STOP: tx_o=1.
- Accept: at an edge where valid_i=1 and ready_o=1:
  - data_i is loaded into the shift register.
  - state->START, tx_o<=0, ready_o<=0, busy_o<=1.
  - data_i and valid_i are ignored until the next accept.
- Bit timer: counts 0..CLKS_PER_BIT-1. At terminal count it resets to 0 and advances the bit.
  - START -> DATA: tx_o<=data bit 0.
  - DATA bit k -> bit k+1: shift right, tx_o<=next bit.
  - After bit WIDTH-1 -> STOP: tx_o<=1.
  - STOP terminal count -> IDLE: ready_o<=1, busy_o<=0, done_o<=1 for exactly one cycle.
- Frame timing: each level on tx_o lasts exactly CLKS_PER_BIT cycles. The frame occupies (WIDTH+2)*CLKS_PER_BIT cycles from the accept edge to the edge that raises done_o.
- Back-to-back: valid_i held high gives the next accept on the edge after ready_o rises. There is therefore exactly one extra idle-high cycle between the stop bit and the next start bit. No word is lost or duplicated.
- done_o and ready_o rise on the same edge. An accept can coincide with the done_o cycle.
- Counter widths: $clog2 of CLKS_PER_BIT (minimum 1 bit) and $clog2 of WIDTH (minimum 1 bit). No overflow is possible within legal parameter values.
- No output is combinational from any input.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> tx_o=1, ready_o=0, busy_o=0 during reset. ready_o=1 after the first edge following release. tx_o stays 1 with valid_i=0.
2. WIDTH=8, CLKS_PER_BIT=4; accept data_i=0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level exactly 4 cycles. done_o pulses once, 40 cycles after the accept edge. busy_o is high throughout.
3. Hold valid_i=1 with 0x00 then 0xFF -> two frames. Second start bit begins exactly 1 idle-high cycle after the first stop bit ends. Two done_o pulses.
4. Accept 0x3C, then change data_i to 0xFF and toggle valid_i mid-frame -> serialized bits still equal 0x3C. No second accept occurs before ready_o returns.
5. Assert reset during data bit 3, between clock edges -> tx_o=1 immediately. No done_o. After release, a new 0x81 frame transmits correctly.
6. CLKS_PER_BIT=1 instance; accept 0x01 -> tx_o sequence 0,1,0,0,0,0,0,0,0,1, one cycle each. done_o 10 cycles after the accept edge.
